layer_stim_seq: RTL and testbench

- Synthesizable, parametrised sequencer that drives the start / need_data control of a conv layer top such as the dense layer blocks.
- Generalises a fixed-timing clock/reset/start bench into several capabilities: programmable start delay and pulse widths, N data requests per frame, multiple frames or continuous operation, CH_NUM request channels served round-robin, and back-pressure from the layer.
- Sits between the system controller (or bench top) and the layer top.

---
 rtl/layer_stim_seq.sv | 189 ++++++++++++++++++
 tb/tb_layer_stim_seq.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_stim_seq.sv
// Start / need_data sequencer for a conv layer top: programmable delays and pulse
// widths, multi-frame or continuous runs, round-robin request channels, back-pressure.
module layer_stim_seq #(
  parameter int unsigned START_DLY = 2,
  parameter int unsigned START_LEN = 1,
  parameter int unsigned REQ_NUM   = 2,
  parameter int unsigned REQ_LEN   = 1,
  parameter int unsigned REQ_GAP   = 10,
  parameter int unsigned FRAME_NUM = 1,
  parameter int unsigned CH_NUM    = 1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dut_busy,
  output logic              start,
  output logic [CH_NUM-1:0] need_data,
  output logic [15:0]       frame_idx,
  output logic [CNT_W-1:0]  req_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_START, S_GAP, S_REQ, S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [CH_W-1:0]   r_ch, w_ch_nxt, w_ch_inc;
  logic [15:0]       r_frame, w_frame_nxt, w_frame_inc;
  logic [CNT_W-1:0]  r_req, w_req_nxt, w_req_inc;
  logic              r_start, w_start_nxt;
  logic [CH_NUM-1:0] r_need, w_need_nxt, w_onehot;
  logic              r_busy, r_done, w_done_nxt;
  logic              w_cnt_last, w_last_req, w_more_frames;

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < int'(CH_NUM); i++) begin
      w_onehot[i] = (r_ch == CH_W'(i));
    end
  end

  assign w_cnt_last    = (r_cnt == CNT_W'(1));
  assign w_req_inc     = r_req + CNT_W'(1);
  assign w_last_req    = (w_req_inc == CNT_W'(REQ_NUM));
  assign w_frame_inc   = (r_frame == 16'hFFFF) ? r_frame : r_frame + 16'd1;
  assign w_more_frames = (FRAME_NUM == 0) || ((32'(r_frame) + 32'd1) < FRAME_NUM);
  assign w_ch_inc      = (r_ch == CH_W'(CH_NUM - 1)) ? '0 : r_ch + CH_W'(1);

  // Next state plus the registered-output values for the cycle after the edge
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ch_nxt    = r_ch;
    w_frame_nxt = r_frame;
    w_req_nxt   = r_req;
    w_start_nxt = 1'b0;
    w_need_nxt  = '0;
    w_done_nxt  = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (en) begin
          w_frame_nxt = '0;
          w_req_nxt   = '0;
          w_ch_nxt    = '0;
          if (START_DLY == 0) begin
            w_state_nxt = S_START;
            w_cnt_nxt   = CNT_W'(START_LEN);
            w_start_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = CNT_W'(START_DLY);
          end
        end
      end
      S_WAIT: begin
        if (w_cnt_last) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = CNT_W'(START_LEN);
          w_start_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_START: begin
        if (w_cnt_last) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = CNT_W'(REQ_GAP);
        end else begin
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_start_nxt = 1'b1;
        end
      end
      S_GAP: begin
        // Back-pressure only matters once the gap has fully elapsed
        if (w_cnt_last) begin
          if (!dut_busy) begin
            w_state_nxt = S_REQ;
            w_cnt_nxt   = CNT_W'(REQ_LEN);
            w_need_nxt  = w_onehot;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_REQ: begin
        if (w_cnt_last) begin
          w_ch_nxt  = w_ch_inc;
          w_req_nxt = w_req_inc;
          if (w_last_req) begin
            w_frame_nxt = w_frame_inc;
            if (w_more_frames) begin
              w_req_nxt   = '0;
              w_state_nxt = S_START;
              w_cnt_nxt   = CNT_W'(START_LEN);
              w_start_nxt = 1'b1;
            end else begin
              w_state_nxt = S_FIN;
              w_cnt_nxt   = '0;
              w_done_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = S_GAP;
            w_cnt_nxt   = CNT_W'(REQ_GAP);
          end
        end else begin
          w_cnt_nxt  = r_cnt - CNT_W'(1);
          w_need_nxt = w_onehot;
        end
      end
      S_FIN: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Abort: indices are kept for debug, everything else drops
    if ((r_state != S_IDLE) && !en) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_ch_nxt    = r_ch;
      w_frame_nxt = r_frame;
      w_req_nxt   = r_req;
      w_start_nxt = 1'b0;
      w_need_nxt  = '0;
      w_done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ch    <= '0;
      r_frame <= '0;
      r_req   <= '0;
      r_start <= 1'b0;
      r_need  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ch    <= w_ch_nxt;
      r_frame <= w_frame_nxt;
      r_req   <= w_req_nxt;
      r_start <= w_start_nxt;
      r_need  <= w_need_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign start     = r_start;
  assign need_data = r_need;
  assign frame_idx = r_frame;
  assign req_idx   = r_req;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_layer_stim_seq.sv
// Three differently parametrised sequencers share random en/dut_busy/rst stimulus and are
// compared every cycle against a sequential-program model of a run.
module tb_layer_stim_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic dut_busy = 1'b0;

  always #5 clk = ~clk;

  logic        a_start, a_busy, a_done;
  logic [0:0]  a_need;
  logic [15:0] a_frame, a_req;
  logic        b_start, b_busy, b_done;
  logic [2:0]  b_need;
  logic [15:0] b_frame, b_req;
  logic        c_start, c_busy, c_done;
  logic [1:0]  c_need;
  logic [15:0] c_frame, c_req;

  layer_stim_seq u_a (
    .clk(clk), .rst(rst), .en(en), .dut_busy(dut_busy),
    .start(a_start), .need_data(a_need), .frame_idx(a_frame), .req_idx(a_req),
    .busy(a_busy), .done(a_done)
  );

  layer_stim_seq #(
    .START_DLY(0), .START_LEN(2), .REQ_NUM(4), .REQ_LEN(2), .REQ_GAP(2),
    .FRAME_NUM(2), .CH_NUM(3), .CNT_W(16)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .dut_busy(dut_busy),
    .start(b_start), .need_data(b_need), .frame_idx(b_frame), .req_idx(b_req),
    .busy(b_busy), .done(b_done)
  );

  layer_stim_seq #(
    .START_DLY(1), .START_LEN(1), .REQ_NUM(3), .REQ_LEN(1), .REQ_GAP(1),
    .FRAME_NUM(0), .CH_NUM(2), .CNT_W(16)
  ) u_c (
    .clk(clk), .rst(rst), .en(en), .dut_busy(dut_busy),
    .start(c_start), .need_data(c_need), .frame_idx(c_frame), .req_idx(c_req),
    .busy(c_busy), .done(c_done)
  );

  logic        d_start[3], d_busy[3], d_done[3];
  logic [2:0]  d_need[3];
  logic [15:0] d_frame[3], d_req[3];

  assign d_start[0] = a_start; assign d_start[1] = b_start; assign d_start[2] = c_start;
  assign d_busy[0]  = a_busy;  assign d_busy[1]  = b_busy;  assign d_busy[2]  = c_busy;
  assign d_done[0]  = a_done;  assign d_done[1]  = b_done;  assign d_done[2]  = c_done;
  assign d_need[0]  = 3'(a_need); assign d_need[1] = b_need; assign d_need[2] = 3'(c_need);
  assign d_frame[0] = a_frame; assign d_frame[1] = b_frame; assign d_frame[2] = c_frame;
  assign d_req[0]   = a_req;   assign d_req[1]   = b_req;   assign d_req[2]   = c_req;

  logic        e_start[3] = '{default: 1'b0};
  logic        e_busy[3]  = '{default: 1'b0};
  logic        e_done[3]  = '{default: 1'b0};
  logic [2:0]  e_need[3]  = '{default: 3'd0};
  logic [15:0] e_frame[3] = '{default: 16'd0};
  logic [15:0] e_req[3]   = '{default: 16'd0};

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the model: 2 = reset seen, 1 = abort (en low), 0 = keep going
  task automatic step(output int code);
    @(posedge clk);
    if (!rst) code = 2;
    else if (!en) code = 1;
    else code = 0;
  endtask

  task automatic set_out(input int idx, input logic s, input logic [2:0] n, input logic b,
                         input logic d);
    e_start[idx] = s;
    e_need[idx]  = n;
    e_busy[idx]  = b;
    e_done[idx]  = d;
  endtask

  // A whole run written as a program: delay, then frames of start + gapped requests
  task automatic run_once(input int idx, input int sdly, input int slen, input int rnum,
                          input int rlen, input int rgap, input int fnum, input int chn,
                          output int code);
    int ch;
    int fr;
    code = 0;
    ch = 0;
    fr = 0;
    e_frame[idx] = 16'd0;
    e_req[idx]   = 16'd0;
    set_out(idx, 1'b0, 3'd0, 1'b1, 1'b0);
    for (int i = 0; i < sdly; i++) begin
      step(code); if (code != 0) return;
    end
    forever begin
      set_out(idx, 1'b1, 3'd0, 1'b1, 1'b0);
      for (int i = 1; i < slen; i++) begin
        step(code); if (code != 0) return;
      end
      step(code); if (code != 0) return;
      for (int r = 0; r < rnum; r++) begin
        set_out(idx, 1'b0, 3'd0, 1'b1, 1'b0);
        for (int i = 1; i < rgap; i++) begin
          step(code); if (code != 0) return;
        end
        step(code); if (code != 0) return;
        while (dut_busy) begin
          step(code); if (code != 0) return;
        end
        set_out(idx, 1'b0, 3'(1 << ch), 1'b1, 1'b0);
        for (int i = 1; i < rlen; i++) begin
          step(code); if (code != 0) return;
        end
        step(code); if (code != 0) return;
        ch = (ch + 1) % chn;
        e_req[idx] = 16'(r + 1);
      end
      fr++;
      if (e_frame[idx] != 16'hFFFF) e_frame[idx] = e_frame[idx] + 16'd1;
      if (fnum == 0 || fr < fnum) begin
        e_req[idx] = 16'd0;
      end else begin
        set_out(idx, 1'b0, 3'd0, 1'b1, 1'b1);
        step(code); if (code == 2) return;
        set_out(idx, 1'b0, 3'd0, 1'b0, 1'b0);
        code = 0;
        return;
      end
    end
  endtask

  task automatic model(input int idx, input int sdly, input int slen, input int rnum,
                       input int rlen, input int rgap, input int fnum, input int chn);
    int code;
    forever begin
      @(posedge clk);
      if (!rst) begin
        set_out(idx, 1'b0, 3'd0, 1'b0, 1'b0);
        e_frame[idx] = 16'd0;
        e_req[idx]   = 16'd0;
      end else if (en) begin
        run_once(idx, sdly, slen, rnum, rlen, rgap, fnum, chn, code);
        if (code != 0) set_out(idx, 1'b0, 3'd0, 1'b0, 1'b0);
        if (code == 2) begin
          e_frame[idx] = 16'd0;
          e_req[idx]   = 16'd0;
        end
      end
    end
  endtask

  initial model(0, 2, 1, 2, 1, 10, 1, 1);
  initial model(1, 0, 2, 4, 2, 2, 2, 3);
  initial model(2, 1, 1, 3, 1, 1, 0, 2);

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  // First-run timing of the default instance, recorded as absolute edge numbers
  logic rec = 1'b0;
  int t_st = -1, t_n1 = -1, t_n2 = -1, t_dn = -1;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("u%0d.start", i), 32'(d_start[i]), 32'(e_start[i]));
      check_val($sformatf("u%0d.need", i),  32'(d_need[i]),  32'(e_need[i]));
      check_val($sformatf("u%0d.busy", i),  32'(d_busy[i]),  32'(e_busy[i]));
      check_val($sformatf("u%0d.done", i),  32'(d_done[i]),  32'(e_done[i]));
      check_val($sformatf("u%0d.frame", i), 32'(d_frame[i]), 32'(e_frame[i]));
      check_val($sformatf("u%0d.req", i),   32'(d_req[i]),   32'(e_req[i]));
    end
    if (rec) begin
      if (d_start[0] === 1'b1 && t_st < 0) t_st = edge_n;
      if (d_need[0][0] === 1'b1) begin
        if (t_n1 < 0) t_n1 = edge_n;
        else if (t_n2 < 0) t_n2 = edge_n;
      end
      if (d_done[0] === 1'b1 && t_dn < 0) t_dn = edge_n;
    end
  end

  int l_edge;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Default run launched with en held high; later runs relaunch back to back
    l_edge = edge_n + 1;
    en = 1'b1;
    rec = 1'b1;
    repeat (30) @(negedge clk);
    rec = 1'b0;
    repeat (120) @(negedge clk);
    check_val("tp.start_edge", 32'(t_st - l_edge), 32'd2);
    check_val("tp.req0_edge",  32'(t_n1 - l_edge), 32'd13);
    check_val("tp.req1_edge",  32'(t_n2 - l_edge), 32'd24);
    check_val("tp.done_edge",  32'(t_dn - l_edge), 32'd25);
    en = 1'b0;
    repeat (4) @(negedge clk);

    // Back-pressure window spanning the first terminal gap count
    en = 1'b1;
    repeat (9) @(negedge clk);
    dut_busy = 1'b1;
    repeat (8) @(negedge clk);
    dut_busy = 1'b0;
    repeat (40) @(negedge clk);

    // Abort mid-run, then reset mid-run with en high
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (12) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    repeat (13) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);

    // Random soak
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      en       = ($urandom_range(0, 149) != 0);
      dut_busy = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 599) != 0);
      if (($urandom_range(0, 399) == 0)) begin
        en = 1'b0;
        repeat ($urandom_range(1, 6)) @(negedge clk);
      end
    end

    en = 1'b0;
    dut_busy = 1'b0;
    rst = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
